// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with valid/ready intake
// Loads a WIDTH-bit word and emits one bit per clk; the next word may load on the last bit.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             serial_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             serial_out_q, serial_out_d;
    logic             serial_valid_q, serial_valid_d;

    logic at_last;
    logic accept;

    assign at_last       = (state_q == SHIFT) && (count_q == LAST);
    assign data_in_ready = (state_q == IDLE) || at_last;
    assign accept        = data_in_valid && data_in_ready;

    assign serial_out    = serial_out_q;
    assign serial_valid  = serial_valid_q;
    assign serial_last   = serial_valid_q && (count_q == LAST);

    always_comb begin
        state_d        = state_q;
        shift_reg_d    = shift_reg_q;
        count_d        = count_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;

        if (accept) begin
            // Loading on the last bit keeps serial_valid high for gapless streaming.
            state_d        = SHIFT;
            shift_reg_d    = data_in;
            count_d        = '0;
            serial_valid_d = 1'b1;
            serial_out_d   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        end else if (state_q == SHIFT && !at_last) begin
            count_d = count_q + CW'(1);
            if (MSB_FIRST) begin
                shift_reg_d  = shift_reg_q << 1;
                serial_out_d = shift_reg_q[WIDTH-2];
            end else begin
                shift_reg_d  = shift_reg_q >> 1;
                serial_out_d = shift_reg_q[1];
            end
        end else begin
            state_d        = IDLE;
            count_d        = '0;
            serial_out_d   = 1'b0;
            serial_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_reg_q    <= '0;
            count_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_reg_q    <= shift_reg_d;
            count_q        <= count_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed bench for piso_serializer (4-bit MSB-first and 8-bit LSB-first)
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [3:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    logic       serial_out;
    logic       serial_valid;
    logic       serial_last;

    logic [7:0] data8;
    logic       valid8;
    logic       ready8;
    logic       sout8;
    logic       svalid8;
    logic       slast8;

    int checks;
    int errors;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .serial_valid  (serial_valid),
        .serial_last   (serial_last)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data8),
        .data_in_valid (valid8),
        .data_in_ready (ready8),
        .serial_out    (sout8),
        .serial_valid  (svalid8),
        .serial_last   (slast8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({serial_valid, serial_out, data_in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_immediate: valid/out/ready=%b required 001", {serial_valid, serial_out, data_in_ready});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({serial_valid, serial_out, data_in_ready, serial_last} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release: valid/out/ready/last=%b required 0010", {serial_valid, serial_out, data_in_ready, serial_last});
        end
        checks++;
        if ({svalid8, sout8, ready8} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release_w8: valid/out/ready=%b required 001", {svalid8, sout8, ready8});
        end
    endtask

    task automatic test_single_word;
        logic [3:0] exp_bits;
        logic [3:0] sipo;
        exp_bits = 4'b1011;
        sipo = 4'b0000;
        data_in = 4'b1011;
        data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) data_in_valid = 1'b0;
            if (serial_valid) sipo = {sipo[2:0], serial_out};
            checks++;
            if ({serial_valid, serial_out, serial_last} !== {1'b1, exp_bits[3-i], (i == 3)}) begin
                errors++;
                $display("FAIL single_bit%0d: valid/out/last=%b required %b", i,
                         {serial_valid, serial_out, serial_last}, {1'b1, exp_bits[3-i], (i == 3)});
            end
        end
        checks++;
        if (sipo !== 4'b1011) begin
            errors++;
            $display("FAIL single_sipo: got %b required 1011", sipo);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({serial_valid, serial_out} !== 2'b00) begin
            errors++;
            $display("FAIL single_cycle5: valid/out=%b required 00", {serial_valid, serial_out});
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0011;
        data_in = 4'hA;
        data_in_valid = 1'b1;
        checks++;
        if (data_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_c0: got %b required 1", data_in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({serial_valid, serial_out} !== {1'b1, exp_bits[7-i]}) begin
                errors++;
                $display("FAIL b2b_bit%0d: valid/out=%b required %b", i, {serial_valid, serial_out}, {1'b1, exp_bits[7-i]});
            end
            checks++;
            if (data_in_ready !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b required %b", i, data_in_ready, ((i % 4) == 3));
            end
            if (i == 3) data_in = 4'h3;
            if (i == 7) data_in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: valid=%b required 0", serial_valid);
        end
    endtask

    task automatic test_busy_ignore;
        logic [3:0] sipo;
        sipo = 4'b0000;
        data_in = 4'b1001;
        data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (serial_valid) sipo = {sipo[2:0], serial_out};
            checks++;
            if (data_in_ready !== (i == 3)) begin
                errors++;
                $display("FAIL busy_ready%0d: got %b required %b", i, data_in_ready, (i == 3));
            end
            case (i)
                0: begin data_in = 4'hF; data_in_valid = 1'b1; end
                1: data_in = 4'h0;
                2: data_in = 4'h5;
                default: data_in_valid = 1'b0;
            endcase
        end
        checks++;
        if (sipo !== 4'b1001) begin
            errors++;
            $display("FAIL busy_word: got %b required 1001", sipo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_accept: valid=%b required 0", serial_valid);
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] exp_bits;
        data_in = 4'b1100;
        data_in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            data_in_valid = 1'b0;
        end
        checks++;
        if ({serial_valid, serial_out} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_pre: valid/out=%b required 11", {serial_valid, serial_out});
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({serial_valid, serial_out, data_in_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_immediate: valid/out/ready=%b required 001", {serial_valid, serial_out, data_in_ready});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (serial_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: valid=%b required 0", serial_valid);
        end
        exp_bits = 4'b0110;
        data_in = 4'b0110;
        data_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            data_in_valid = 1'b0;
            checks++;
            if ({serial_valid, serial_out, serial_last} !== {1'b1, exp_bits[3-i], (i == 3)}) begin
                errors++;
                $display("FAIL midrst_bit%0d: valid/out/last=%b required %b", i,
                         {serial_valid, serial_out, serial_last}, {1'b1, exp_bits[3-i], (i == 3)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_width8_lsb;
        logic [7:0] word;
        logic [7:0] rec;
        int         lasts;
        int         gap;
        for (int w = 0; w < 16; w++) begin
            word = 8'($urandom);
            checks++;
            if (ready8 !== 1'b1) begin
                errors++;
                $display("FAIL w8_ready%0d: got %b required 1", w, ready8);
            end
            data8 = word;
            valid8 = 1'b1;
            rec = 8'h00;
            lasts = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) begin
                    valid8 = 1'b0;
                    data8 = ~word;
                end
                checks++;
                if ({svalid8, sout8} !== {1'b1, word[i]}) begin
                    errors++;
                    $display("FAIL w8_word%0d_bit%0d: valid/out=%b required %b", w, i, {svalid8, sout8}, {1'b1, word[i]});
                end
                rec[i] = sout8;
                if (slast8) lasts++;
            end
            checks++;
            if (rec !== word) begin
                errors++;
                $display("FAIL w8_word%0d: got %h required %h", w, rec, word);
            end
            checks++;
            if (lasts !== 1 || slast8 !== 1'b1) begin
                errors++;
                $display("FAIL w8_last%0d: count %0d final %b required 1 1", w, lasts, slast8);
            end
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                checks++;
                if ({svalid8, slast8, sout8} !== 3'b000) begin
                    errors++;
                    $display("FAIL w8_gap%0d: valid/last/out=%b required 000", w, {svalid8, slast8, sout8});
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        data_in = 4'h0;
        data_in_valid = 1'b0;
        data8 = 8'h00;
        valid8 = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_width8_lsb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the counterpart of our serial-in, parallel-out shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clk on serial_out.
- Bit order is chosen so that a downstream SIPO doing out <= {out[WIDTH-2:0], in} holds the original word after WIDTH shifts.
- Used as the lab's serial link source and as bench stimulus for the SIPO.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first (matches the SIPO); 0 = transmit bit 0 first.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  WIDTH  parallel word; sampled only on the accept edge.
- data_in_valid  input  1  producer has a word.
- data_in_ready  output  1  block can take a word this cycle (combinational from state/count).
- serial_out  output  WIDTH=1  serial data bit, registered.
- serial_valid  output  1  serial_out holds a live bit, registered.
- serial_last  output  1  current bit is the final bit of the word (serial_valid && count==WIDTH-1).

Behaviour:
- State: IDLE / SHIFT; shift_reg[WIDTH-1:0]; bit counter count, width clog2(WIDTH).
- Reset (async, takes effect immediately, mid-word included): state=IDLE, shift_reg=0, count=0, serial_out=0, serial_valid=0, serial_last=0, data_in_ready=1. The word in flight is dropped with no partial completion.
- data_in_ready = (state==IDLE) || (state==SHIFT && count==WIDTH-1).
- Accept = data_in_valid && data_in_ready at posedge.
  - On accept: shift_reg<=data_in, count<=0, state<=SHIFT, serial_valid<=1.
  - serial_out<=data_in[WIDTH-1] if MSB_FIRST, else data_in[0].
- Latency: first bit visible on serial_out the cycle after the accept edge. Each word occupies exactly WIDTH consecutive cycles of serial_valid=1.
- In SHIFT with count<WIDTH-1, each posedge:
  - count<=count+1.
  - Shift toward the output end; MSB_FIRST shifts left.
  - serial_out<=next bit.
  - data_in_valid is ignored and data_in is not sampled.
- In SHIFT with count==WIDTH-1 (last bit on wire):
  - If accept, load the new word as above. Zero-gap back-to-back streaming: serial_valid stays 1, count wraps to 0.
  - Otherwise state<=IDLE, serial_valid<=0, serial_out<=0, count<=0.
- In IDLE without accept: outputs hold 0 and serial_valid=0.
- Changes on data_in after the accept edge must not affect the transmitted word.
- X on data_in_valid while ready is a bench error. The block does not need to tolerate it.

Test Plan:
- Reset check: assert rst for 3 cycles, including one assertion between clock edges.
  - Required: serial_valid=0, serial_out=0, data_in_ready=1 immediately and after release.
- Single word: data_in=4'b1011 with valid for 1 cycle.
  - Required: serial_out=1,0,1,1 on the 4 following cycles with serial_valid=1 and serial_last only on the 4th.
  - A SIPO model fed serial_out reads 4'b1011. serial_valid=0 on cycle 5.
- Back-to-back: valid held high with 4'hA then 4'h3 presented at each ready.
  - Required: 8 contiguous valid bits 1,0,1,0,0,0,1,1 with no idle gap; data_in_ready high only on cycles 0, 4, 8.
- Busy ignore: during a word, pulse valid with data_in=4'hF and change data_in every cycle.
  - Required: the transmitted word is unchanged and the 4'hF is not accepted.
- Mid-word reset: assert rst after 2 bits of 4'b1100.
  - Required: serial_valid drops immediately. After release, a new word 4'b0110 transmits cleanly as 0,1,1,0.
- Parameter sweep: WIDTH=8, MSB_FIRST=0, 16 random words with random idle gaps.
  - Required: bit order LSB first, every word reconstructed exactly, serial_last once per word.
